// File: rtl/parity16_serial_checker_if.sv
// Word-side and serial-side signals of the parity16 serial checker.
// master = link front-end / consumer side, slave = the checker itself.
interface parity16_serial_checker_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic                 frame_abort;
    logic [15:0]          word_out;
    logic                 parity_err;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output bit_in, bit_valid, frame_abort, out_ready, err_clr,
        input  bit_ready, word_out, parity_err, out_valid, err_count
    );

    modport slave (
        input  bit_in, bit_valid, frame_abort, out_ready, err_clr,
        output bit_ready, word_out, parity_err, out_valid, err_count
    );
endinterface

// File: rtl/parity16_serial_checker.sv
// Serial receiver for 17-bit frames (16 data bits LSB first + parity bit).
// Recomputes parity, presents the word on valid/ready and keeps a
// saturating count of frames that arrived with a parity error.
module parity16_serial_checker #(
    parameter int PARITY_ODD = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    parity16_serial_checker_if.slave  bus
);
    typedef enum logic {SHIFT, HOLD} state_t;

    localparam logic ODD = (PARITY_ODD != 0);

    state_t               state;
    logic [4:0]           idx;
    logic [15:0]          sr;
    logic                 rx;
    logic [15:0]          word_q;
    logic                 perr_q;
    logic                 ovld_q;
    logic [ERR_CNT_W-1:0] cnt;

    logic accept;
    logic last_bit;
    logic frame_err;

    assign accept    = bus.bit_valid & ~ovld_q;
    // Parity bit accepted and not killed by an abort in the same cycle.
    assign last_bit  = (state == SHIFT) & accept & ~bus.frame_abort & (idx == 5'd16);
    assign frame_err = rx ^ bus.bit_in ^ ODD;

    assign bus.bit_ready  = ~ovld_q;
    assign bus.word_out   = word_q;
    assign bus.parity_err = perr_q;
    assign bus.out_valid  = ovld_q;
    assign bus.err_count  = cnt;

    // Frame FSM: shift data bits in, check parity, hold word until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SHIFT;
            idx    <= '0;
            sr     <= '0;
            rx     <= 1'b0;
            word_q <= '0;
            perr_q <= 1'b0;
            ovld_q <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    if (bus.frame_abort) begin
                        // Stale bits left in sr are overwritten by the next frame.
                        idx <= '0;
                        rx  <= 1'b0;
                    end else if (accept) begin
                        if (idx == 5'd16) begin
                            word_q <= sr;
                            perr_q <= frame_err;
                            ovld_q <= 1'b1;
                            idx    <= '0;
                            rx     <= 1'b0;
                            state  <= HOLD;
                        end else begin
                            sr[idx[3:0]] <= bus.bit_in;
                            rx           <= rx ^ bus.bit_in;
                            idx          <= idx + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    // Abort is ignored here; only the consumer releases the word.
                    if (bus.out_ready) begin
                        ovld_q <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

    // Saturating error counter; clear wins over a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (bus.err_clr) begin
            cnt <= '0;
        end else if (last_bit && frame_err && (cnt != {ERR_CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_parity16_serial_checker.sv
// Bench for parity16_serial_checker: an even-parity and an odd-parity
// instance share one stimulus stream and are checked against a
// frame-level reference model.
module tb_parity16_serial_checker;
    logic clk = 1'b0;
    logic rst;
    logic bit_in, bit_valid, frame_abort, out_ready, err_clr;

    always #5 clk = ~clk;

    parity16_serial_checker_if #(.ERR_CNT_W(8)) ife ();
    parity16_serial_checker_if #(.ERR_CNT_W(8)) ifo ();

    assign ife.bit_in = bit_in;      assign ifo.bit_in = bit_in;
    assign ife.bit_valid = bit_valid; assign ifo.bit_valid = bit_valid;
    assign ife.frame_abort = frame_abort; assign ifo.frame_abort = frame_abort;
    assign ife.out_ready = out_ready; assign ifo.out_ready = out_ready;
    assign ife.err_clr = err_clr;    assign ifo.err_clr = err_clr;

    parity16_serial_checker #(.PARITY_ODD(0), .ERR_CNT_W(8)) u_even (
        .clk(clk), .rst(rst), .bus(ife.slave));
    parity16_serial_checker #(.PARITY_ODD(1), .ERR_CNT_W(8)) u_odd (
        .clk(clk), .rst(rst), .bus(ifo.slave));

    // index 0 = even instance, 1 = odd instance
    logic [15:0] o_word[2];
    logic        o_perr[2], o_ovld[2], o_brdy[2];
    logic [7:0]  o_cnt[2];
    assign o_word[0] = ife.word_out;   assign o_word[1] = ifo.word_out;
    assign o_perr[0] = ife.parity_err; assign o_perr[1] = ifo.parity_err;
    assign o_ovld[0] = ife.out_valid;  assign o_ovld[1] = ifo.out_valid;
    assign o_brdy[0] = ife.bit_ready;  assign o_brdy[1] = ifo.bit_ready;
    assign o_cnt[0]  = ife.err_count;  assign o_cnt[1]  = ifo.err_count;

    // Reference model state
    logic [15:0] m_word;
    logic        m_perr[2];
    logic        m_ovld;
    int          m_cnt[2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] w, input int gap);
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, gap)) tick();
            send_bit(w[i]);
        end
    endtask

    // Frame-level model: a completed frame publishes the word and bumps the
    // error count when the 17 received bits violate the chosen parity rule.
    task automatic model_frame(input logic [15:0] w, input logic p, input logic clr);
        m_word = w;
        m_ovld = 1'b1;
        for (int m = 0; m < 2; m++) begin
            m_perr[m] = ((($countones(w) + int'(p)) % 2) != m);
            if (clr) m_cnt[m] = 0;
            else if (m_perr[m] && m_cnt[m] < 255) m_cnt[m]++;
        end
    endtask

    task automatic model_reset;
        m_word = '0;
        m_ovld = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_perr[m] = 1'b0;
            m_cnt[m]  = 0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bit_in = 0; bit_valid = 0; frame_abort = 0; out_ready = 1; err_clr = 0;
        model_reset();
        repeat (2) tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_word[m] !== m_word || o_perr[m] !== 1'b0 || o_ovld[m] !== 1'b0 ||
                o_cnt[m] !== 8'd0 || o_brdy[m] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset[%0d]: word=%h perr=%b ovld=%b cnt=%0d rdy=%b, want all 0 rdy=1",
                         m, o_word[m], o_perr[m], o_ovld[m], o_cnt[m], o_brdy[m]);
            end
        end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_frame(input string name, input logic [15:0] w, input logic p,
                              input int gap);
        send_data(w, gap);
        send_bit(p);
        model_frame(w, p, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ovld[m] !== 1'b1 || o_word[m] !== m_word || o_perr[m] !== m_perr[m] ||
                o_cnt[m] !== m_cnt[m][7:0] || o_brdy[m] !== 1'b0) begin
                n_bad++;
                $display("FAIL %s[%0d]: ovld=%b word=%h perr=%b cnt=%0d rdy=%b, want 1 %h %b %0d 0",
                         name, m, o_ovld[m], o_word[m], o_perr[m], o_cnt[m], o_brdy[m],
                         m_word, m_perr[m], m_cnt[m]);
            end
        end
        tick();
        m_ovld = 1'b0;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ovld[m] !== 1'b0 || o_brdy[m] !== 1'b1 || o_word[m] !== m_word) begin
                n_bad++;
                $display("FAIL %s_release[%0d]: ovld=%b rdy=%b word=%h, want 0 1 %h",
                         name, m, o_ovld[m], o_brdy[m], o_word[m], m_word);
            end
        end
    endtask

    task automatic test_err_clr;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_cnt[m] !== 8'd0) begin
                n_bad++;
                $display("FAIL err_clr[%0d]: cnt=%0d want 0", m, o_cnt[m]);
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send_data(16'h1234, 0);
        send_bit(1'b1);
        model_frame(16'h1234, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            // bits offered during HOLD must be refused
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ovld[m] !== 1'b1 || o_brdy[m] !== 1'b0 || o_word[m] !== 16'h1234 ||
                    o_perr[m] !== m_perr[m]) begin
                    n_bad++;
                    $display("FAIL hold%0d[%0d]: ovld=%b rdy=%b word=%h perr=%b, want 1 0 1234 %b",
                             c, m, o_ovld[m], o_brdy[m], o_word[m], o_perr[m], m_perr[m]);
                end
            end
            tick();
        end
        bit_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ovld[m] !== 1'b0 || o_brdy[m] !== 1'b1 || o_cnt[m] !== m_cnt[m][7:0]) begin
                n_bad++;
                $display("FAIL bp_release[%0d]: ovld=%b rdy=%b cnt=%0d, want 0 1 %0d",
                         m, o_ovld[m], o_brdy[m], o_cnt[m], m_cnt[m]);
            end
        end
    endtask

    task automatic test_abort;
        for (int i = 0; i < 5; i++) send_bit(1'($urandom));
        frame_abort = 1'b1;
        send_bit(1'b1);
        frame_abort = 1'b0;
        test_frame("abort_then_ffff", 16'hFFFF, 1'b0, 0);
        // abort coincident with the parity bit: frame is dropped
        send_data(16'h0001, 0);
        frame_abort = 1'b1;
        send_bit(1'b0);
        frame_abort = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int m = 0; m < 2; m++) begin
                n_cmp++;
                if (o_ovld[m] !== 1'b0 || o_cnt[m] !== m_cnt[m][7:0] || o_word[m] !== m_word) begin
                    n_bad++;
                    $display("FAIL abort_parity[%0d]: ovld=%b cnt=%0d word=%h, want 0 %0d %h",
                             m, o_ovld[m], o_cnt[m], o_word[m], m_cnt[m], m_word);
                end
            end
            tick();
        end
        test_frame("after_abort", 16'hC3A1, 1'b0, 0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 20; f++)
            test_frame("random", 16'($urandom), 1'($urandom), 2);
    endtask

    task automatic test_saturation;
        logic [15:0] w;
        test_err_clr();
        // parity chosen so the even instance flags every frame, odd none
        for (int f = 0; f < 258; f++) begin
            w = 16'($urandom);
            send_data(w, 0);
            send_bit(~(^w));
            model_frame(w, ~(^w), 1'b0);
            tick();
            m_ovld = 1'b0;
            if (f == 253 || f == 254 || f == 257) begin
                for (int m = 0; m < 2; m++) begin
                    n_cmp++;
                    if (o_cnt[m] !== m_cnt[m][7:0]) begin
                        n_bad++;
                        $display("FAIL sat%0d[%0d]: cnt=%0d want %0d", f, m, o_cnt[m], m_cnt[m]);
                    end
                end
            end
        end
        // error frame and clear on the same edge
        send_data(16'h0001, 0);
        err_clr = 1'b1;
        send_bit(1'b0);
        err_clr = 1'b0;
        model_frame(16'h0001, 1'b0, 1'b1);
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_cnt[m] !== 8'd0 || o_ovld[m] !== 1'b1 || o_perr[m] !== m_perr[m]) begin
                n_bad++;
                $display("FAIL clr_vs_inc[%0d]: cnt=%0d ovld=%b perr=%b, want 0 1 %b",
                         m, o_cnt[m], o_ovld[m], o_perr[m], m_perr[m]);
            end
        end
        tick();
        m_ovld = 1'b0;
    endtask

    task automatic test_async_reset;
        test_frame("pre_rst", 16'h0003, 1'b1, 0);
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_word[m] !== 16'h0 || o_perr[m] !== 1'b0 || o_ovld[m] !== 1'b0 ||
                o_cnt[m] !== 8'd0) begin
                n_bad++;
                $display("FAIL async_rst[%0d]: word=%h perr=%b ovld=%b cnt=%0d, want all 0",
                         m, o_word[m], o_perr[m], o_ovld[m], o_cnt[m]);
            end
        end
        tick();
        #2 rst = 1'b0;
        tick();
        test_frame("odd_zero", 16'h0000, 1'b1, 0);
        // reset while a word is pending
        out_ready = 1'b0;
        send_data(16'hBEEF, 0);
        send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int m = 0; m < 2; m++) begin
            n_cmp++;
            if (o_ovld[m] !== 1'b0 || o_word[m] !== 16'h0 || o_brdy[m] !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_rst[%0d]: ovld=%b word=%h rdy=%b, want 0 0000 1",
                         m, o_ovld[m], o_word[m], o_brdy[m]);
            end
        end
        tick();
        #2 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        test_frame("post_rst", 16'h5A5A, 1'b1, 1);
    endtask

    initial begin
        test_reset();
        test_frame("even_a5a5", 16'hA5A5, 1'b0, 0);
        test_frame("err_0001", 16'h0001, 1'b0, 0);
        test_err_clr();
        test_backpressure();
        test_abort();
        test_random();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
